// File: rtl/ipv4_udp_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_udp_hdr_parser
// Brief    : Taps a 64-bit receive stream, walks the first five beats of each
//            Ethernet frame and presents a host-order IPv4/UDP header record
//            on a registered valid/ready port. Frame data passes through
//            with zero latency and is never back-pressured by the parser.
// Options  : IPV4_CSUM_CHK_EN - verify the IPv4 header checksum; adds one
//            cycle of header latency (fold stage before the record loads).
// Revision : 1.0 - initial release
// ============================================================================
module ipv4_udp_hdr_parser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [47:0] hdr_dst_mac,
  output logic [47:0] hdr_src_mac,
  output logic [15:0] hdr_ethertype,
  output logic [31:0] hdr_src_ip,
  output logic [31:0] hdr_dst_ip,
  output logic [7:0]  hdr_proto,
  output logic [15:0] hdr_sport,
  output logic [15:0] hdr_dport,
  output logic        hdr_is_udp,
  output logic        hdr_csum_ok,
  output logic [15:0] hdr_drop_cnt
);

  localparam logic [15:0] C_ETH_IPV4  = 16'h0800;
  localparam logic [7:0]  C_PROTO_UDP = 8'd17;

  typedef enum logic [1:0] {
    ST_SOF  = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] eth;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [7:0]  proto;
    logic [15:0] sport;
    logic [15:0] dport;
  } hdr_rec_t;

  // Endian conversion: lane 0 (first wire byte) becomes the most significant byte.
  function automatic logic [15:0] endian_conv16(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  function automatic logic [31:0] endian_conv32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [47:0] endian_conv48(input logic [47:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24], x[39:32], x[47:40]};
  endfunction

  // ---------------------------------------------------------------------------
  // Pass-through stream: pure wiring, the parser only observes.
  // ---------------------------------------------------------------------------
  assign m_tdata  = s_tdata;
  assign m_tkeep  = s_tkeep;
  assign m_tlast  = s_tlast;
  assign m_tvalid = s_tvalid;
  assign s_tready = m_tready;

  logic   w_xfer;
  state_t state_q, state_d;
  logic [2:0] beat_cnt_q, beat_cnt_d;
  logic   w_runt;
  logic   w_hdr_done;

  assign w_xfer = s_tvalid && m_tready;

  // FSM state and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SOF;
      beat_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic: walk beats 0..4, flag runts and header completion.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    w_runt     = 1'b0;
    w_hdr_done = 1'b0;
    if (w_xfer) begin
      case (state_q)
        ST_SOF: begin
          if (s_tlast) begin
            w_runt = 1'b1;
          end else begin
            beat_cnt_d = 3'd1;
            state_d    = ST_HDR;
          end
        end
        ST_HDR: begin
          if (beat_cnt_q == 3'd4) begin
            w_hdr_done = 1'b1;
            beat_cnt_d = 3'd0;
            state_d    = s_tlast ? ST_SOF : ST_BODY;
          end else if (s_tlast) begin
            w_runt     = 1'b1;
            beat_cnt_d = 3'd0;
            state_d    = ST_SOF;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
        ST_BODY: begin
          if (s_tlast) state_d = ST_SOF;
        end
        default: begin
          state_d    = ST_SOF;
          beat_cnt_d = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Field capture, kept in wire byte order until the record is assembled.
  // ---------------------------------------------------------------------------
  logic [47:0] cap_dst_q;
  logic [47:0] cap_src_q;
  logic [15:0] cap_eth_q;
  logic [7:0]  cap_proto_q;
  logic [31:0] cap_sip_q;
  logic [15:0] cap_dip_hi_q;
  logic        w_in_hdr;

  assign w_in_hdr = w_xfer && (state_q == ST_HDR);

  // Latch the raw header bytes of beats 0-3 as they transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_dst_q    <= '0;
      cap_src_q    <= '0;
      cap_eth_q    <= '0;
      cap_proto_q  <= '0;
      cap_sip_q    <= '0;
      cap_dip_hi_q <= '0;
    end else if (w_xfer && (state_q == ST_SOF)) begin
      cap_dst_q        <= s_tdata[47:0];
      cap_src_q[15:0]  <= s_tdata[63:48];
    end else if (w_in_hdr) begin
      case (beat_cnt_q)
        3'd1: begin
          cap_src_q[47:16] <= s_tdata[31:0];
          cap_eth_q        <= s_tdata[47:32];
        end
        3'd2: cap_proto_q <= s_tdata[63:56];
        3'd3: begin
          cap_sip_q    <= s_tdata[47:16];
          cap_dip_hi_q <= s_tdata[63:48];
        end
        default: ;
      endcase
    end
  end

  // Complete record as seen during the beat-4 transfer.
  hdr_rec_t w_new;
  assign w_new.dst   = endian_conv48(cap_dst_q);
  assign w_new.src   = endian_conv48(cap_src_q);
  assign w_new.eth   = endian_conv16(cap_eth_q);
  assign w_new.sip   = endian_conv32(cap_sip_q);
  assign w_new.dip   = endian_conv32({s_tdata[15:0], cap_dip_hi_q});
  assign w_new.proto = cap_proto_q;
  assign w_new.sport = endian_conv16(s_tdata[31:16]);
  assign w_new.dport = endian_conv16(s_tdata[47:32]);

  logic     w_load_evt;
  hdr_rec_t w_load_rec;
  logic     w_load_ok;

`ifdef IPV4_CSUM_CHK_EN
  // Sum of the four network-order 16-bit words carried by one beat.
  function automatic logic [17:0] csum_words4(input logic [63:0] d);
    return {2'b00, endian_conv16(d[15:0])}  + {2'b00, endian_conv16(d[31:16])} +
           {2'b00, endian_conv16(d[47:32])} + {2'b00, endian_conv16(d[63:48])};
  endfunction

  logic [19:0] csum_acc_q, csum_acc_d;
  hdr_rec_t    stg_q;
  logic [19:0] stg_sum_q;
  logic        stg_vld_q;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  // Accumulate header words: bytes 14-15 in beat 1, all of beats 2 and 3.
  always_comb begin
    csum_acc_d = csum_acc_q;
    if (w_in_hdr) begin
      case (beat_cnt_q)
        3'd1:       csum_acc_d = {4'd0, endian_conv16(s_tdata[63:48])};
        3'd2, 3'd3: csum_acc_d = csum_acc_q + {2'b00, csum_words4(s_tdata)};
        default: ;
      endcase
    end
  end

  // Stage the finished header and its raw sum (bytes 32-33 added last).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_acc_q <= '0;
      stg_q      <= '0;
      stg_sum_q  <= '0;
      stg_vld_q  <= 1'b0;
    end else begin
      csum_acc_q <= csum_acc_d;
      stg_vld_q  <= w_hdr_done;
      if (w_hdr_done) begin
        stg_q     <= w_new;
        stg_sum_q <= csum_acc_q + {4'd0, endian_conv16(s_tdata[15:0])};
      end
    end
  end

  // Two end-around-carry folds; the second can never carry out again.
  assign w_fold1 = {1'b0, stg_sum_q[15:0]} + {13'd0, stg_sum_q[19:16]};
  assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};

  assign w_load_evt = stg_vld_q;
  assign w_load_rec = stg_q;
  assign w_load_ok  = (w_fold2 == 16'hFFFF) && (stg_q.eth == C_ETH_IPV4);
`else
  assign w_load_evt = w_hdr_done;
  assign w_load_rec = w_new;
  assign w_load_ok  = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Output record, handshake and drop accounting.
  // ---------------------------------------------------------------------------
  hdr_rec_t    rec_q;
  logic        is_udp_q;
  logic        csum_ok_q;
  logic        valid_q;
  logic [15:0] drop_q, drop_d;
  logic        w_load;
  logic        w_ovr;
  logic [1:0]  w_drop_inc;
  logic [16:0] w_drop_sum;

  assign w_load     = w_load_evt && (!valid_q || hdr_ready);
  assign w_ovr      = w_load_evt && valid_q && !hdr_ready;
  assign w_drop_inc = {1'b0, w_runt} + {1'b0, w_ovr};
  assign w_drop_sum = {1'b0, drop_q} + {15'd0, w_drop_inc};
  assign drop_d     = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  // Load a new record when the slot is free or being emptied this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q     <= '0;
      is_udp_q  <= 1'b0;
      csum_ok_q <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      drop_q <= drop_d;
      if (w_load) begin
        rec_q     <= w_load_rec;
        is_udp_q  <= (w_load_rec.eth == C_ETH_IPV4) && (w_load_rec.proto == C_PROTO_UDP);
        csum_ok_q <= w_load_ok;
        valid_q   <= 1'b1;
      end else if (hdr_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign hdr_valid     = valid_q;
  assign hdr_dst_mac   = rec_q.dst;
  assign hdr_src_mac   = rec_q.src;
  assign hdr_ethertype = rec_q.eth;
  assign hdr_src_ip    = rec_q.sip;
  assign hdr_dst_ip    = rec_q.dip;
  assign hdr_proto     = rec_q.proto;
  assign hdr_sport     = rec_q.sport;
  assign hdr_dport     = rec_q.dport;
  assign hdr_is_udp    = is_udp_q;
  assign hdr_csum_ok   = csum_ok_q;
  assign hdr_drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ipv4_udp_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipv4_udp_hdr_parser
// Brief    : Self-checking bench for ipv4_udp_hdr_parser. Frames are built
//            byte-by-byte from field values; expected records come from
//            those field values. Honours IPV4_CSUM_CHK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipv4_udp_hdr_parser;

`ifdef IPV4_CSUM_CHK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] eth;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [7:0]  proto;
    logic [15:0] sport;
    logic [15:0] dport;
    logic        udp;
    logic        ok;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast, s_tvalid, s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
  logic        hdr_valid, hdr_ready;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic [31:0] hdr_src_ip, hdr_dst_ip;
  logic [7:0]  hdr_proto;
  logic [15:0] hdr_sport, hdr_dport;
  logic        hdr_is_udp, hdr_csum_ok;
  logic [15:0] hdr_drop_cnt;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   b4_cyc = 0;
  int   exp_drop = 0;
  logic [7:0] fb [0:127];
  rec_t got_q[$];
  int   got_cyc[$];

  ipv4_udp_hdr_parser dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac), .hdr_ethertype(hdr_ethertype),
    .hdr_src_ip(hdr_src_ip), .hdr_dst_ip(hdr_dst_ip), .hdr_proto(hdr_proto),
    .hdr_sport(hdr_sport), .hdr_dport(hdr_dport), .hdr_is_udp(hdr_is_udp),
    .hdr_csum_ok(hdr_csum_ok), .hdr_drop_cnt(hdr_drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted header (valid && ready seen before the edge).
  always @(negedge clk) begin
    if (rst_n === 1'b1 && hdr_valid === 1'b1 && hdr_ready === 1'b1) begin
      got_q.push_back({hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_src_ip, hdr_dst_ip,
                       hdr_proto, hdr_sport, hdr_dport, hdr_is_udp, hdr_csum_ok});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Build a frame into fb[] with a correct IPv4 checksum; return expected record.
  task automatic make_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] eth,
                            input logic [31:0] sip, input logic [31:0] dip, input logic [7:0] proto,
                            input logic [15:0] sport, input logic [15:0] dport,
                            input int nb, input bit corrupt, output rec_t r);
    int unsigned s;
    logic [15:0] ck;
    for (int i = 0; i < 128; i++) fb[i] = 8'($urandom());
    for (int i = 0; i < 6; i++) begin
      fb[i]     = dst[8*(5-i) +: 8];
      fb[6 + i] = src[8*(5-i) +: 8];
    end
    fb[12] = eth[15:8];  fb[13] = eth[7:0];
    fb[14] = 8'h45;      fb[15] = 8'h00;
    fb[16] = 8'h00;      fb[17] = 8'(nb * 8 - 14);
    fb[20] = 8'h40;      fb[21] = 8'h00;
    fb[22] = 8'd64;      fb[23] = proto;
    fb[24] = 8'h00;      fb[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      fb[26 + i] = sip[8*(3-i) +: 8];
      fb[30 + i] = dip[8*(3-i) +: 8];
    end
    fb[34] = sport[15:8]; fb[35] = sport[7:0];
    fb[36] = dport[15:8]; fb[37] = dport[7:0];
    s = 0;
    for (int i = 14; i < 34; i += 2) s += {16'd0, fb[i], fb[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~s[15:0];
    fb[24] = ck[15:8]; fb[25] = ck[7:0];
    if (corrupt) fb[22] = fb[22] ^ 8'h5A;
    r.dst = dst; r.src = src; r.eth = eth; r.sip = sip; r.dip = dip;
    r.proto = proto; r.sport = sport; r.dport = dport;
    r.udp = (eth == 16'h0800) && (proto == 8'd17);
`ifdef IPV4_CSUM_CHK_EN
    r.ok = !corrupt && (eth == 16'h0800);
`else
    r.ok = 1'b1;
`endif
  endtask

  task automatic drive_beat(input int b, input bit last);
    for (int l = 0; l < 8; l++) s_tdata[8*l +: 8] = fb[8*b + l];
    s_tkeep  = 8'hFF;
    s_tlast  = last;
    s_tvalid = 1'b1;
  endtask

  // Send nb beats of fb[] with m_tready high; leaves s_tvalid asserted.
  task automatic send_frame(input int nb);
    m_tready = 1'b1;
    for (int b = 0; b < nb; b++) begin
      drive_beat(b, b == nb - 1);
      @(posedge clk); #1;
      if (b == 4) b4_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_src_ip, hdr_dst_ip, hdr_proto,
         hdr_sport, hdr_dport, hdr_is_udp, hdr_csum_ok, hdr_drop_cnt} !== '0)
      begin errors++; $display("FAIL reset_state: valid=%b dst=%h drop=%h, want all zero", hdr_valid, hdr_dst_mac, hdr_drop_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_udp;
    rec_t e;
    got_q.delete(); got_cyc.delete();
    hdr_ready = 1'b1;
    make_frame(48'h001122334455, 48'h66778899aabb, 16'h0800, 32'h0A000001, 32'h0A000002,
               8'd17, 16'h1234, 16'h0D80, 8, 1'b0, e);
    send_frame(8);
    idle(5);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL udp_count: got %0d records, want 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== e) begin errors++; $display("FAIL udp_record: got %h want %h", got_q[0], e); end
      checks++;
      if (got_cyc[0] !== b4_cyc + LAT - 1) begin errors++; $display("FAIL udp_latency: valid at cycle %0d want %0d", got_cyc[0], b4_cyc + LAT - 1); end
      checks++;
      if (got_q[0].dst !== 48'h001122334455) begin errors++; $display("FAIL udp_dst: got %h want 001122334455", got_q[0].dst); end
      checks++;
      if (got_q[0].sip !== 32'h0A000001) begin errors++; $display("FAIL udp_sip: got %h want 0a000001", got_q[0].sip); end
      checks++;
      if (got_q[0].dport !== 16'h0D80) begin errors++; $display("FAIL udp_dport: got %h want 0d80", got_q[0].dport); end
      checks++;
      if ({got_q[0].udp, got_q[0].ok} !== 2'b11) begin errors++; $display("FAIL udp_flags: got udp/ok=%b want 11", {got_q[0].udp, got_q[0].ok}); end
    end
    checks++;
    if (hdr_valid !== 1'b0) begin errors++; $display("FAIL udp_valid_drop: got %b want 0", hdr_valid); end
  endtask

  task automatic test_corrupt;
    rec_t e;
    got_q.delete(); got_cyc.delete();
    make_frame(48'h001122334455, 48'h66778899aabb, 16'h0800, 32'h0A000001, 32'h0A000002,
               8'd17, 16'h1234, 16'h0D80, 8, 1'b1, e);
    send_frame(8);
    idle(5);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL corrupt_count: got %0d records, want 1", got_q.size()); end
    else if (got_q[0] !== e) begin errors++; $display("FAIL corrupt_record: got %h want %h", got_q[0], e); end
  endtask

  task automatic test_runt;
    rec_t e;
    got_q.delete(); got_cyc.delete();
    make_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 32'hC0A80101, 32'hC0A80102,
               8'd17, 16'h0400, 16'h0035, 3, 1'b0, e);
    send_frame(3);
    exp_drop++;
    idle(3);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL runt_no_header: got %0d records want 0", got_q.size()); end
    checks++;
    if (hdr_drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL runt_drop: got %0d want %0d", hdr_drop_cnt, exp_drop); end
    make_frame(48'h020000000001, 48'h020000000002, 16'h0800, 32'h01020304, 32'h05060708,
               8'd6, 16'hABCD, 16'h0050, 6, 1'b0, e);
    send_frame(6);
    idle(5);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL runt_next_count: got %0d want 1", got_q.size()); end
    else if (got_q[0] !== e) begin errors++; $display("FAIL runt_next_record: got %h want %h", got_q[0], e); end
  endtask

  task automatic test_overrun;
    rec_t e1, e2;
    got_q.delete(); got_cyc.delete();
    hdr_ready = 1'b0;
    make_frame(48'h111111111111, 48'h222222222222, 16'h0800, 32'h0A0A0A0A, 32'h0B0B0B0B,
               8'd17, 16'h1111, 16'h2222, 5, 1'b0, e1);
    send_frame(5);
    make_frame(48'h333333333333, 48'h444444444444, 16'h0800, 32'h0C0C0C0C, 32'h0D0D0D0D,
               8'd17, 16'h3333, 16'h4444, 5, 1'b0, e2);
    send_frame(5);
    exp_drop++;
    idle(4);
    checks++;
    if ({hdr_valid, hdr_dst_mac, hdr_dport} !== {1'b1, e1.dst, e1.dport})
      begin errors++; $display("FAIL overrun_hold: got valid=%b dst=%h dport=%h want 1 %h %h", hdr_valid, hdr_dst_mac, hdr_dport, e1.dst, e1.dport); end
    checks++;
    if (hdr_drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL overrun_drop: got %0d want %0d", hdr_drop_cnt, exp_drop); end
    hdr_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (hdr_valid !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", hdr_valid); end
    idle(2);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL overrun_count: got %0d want 1", got_q.size()); end
    else if (got_q[0] !== e1) begin errors++; $display("FAIL overrun_record: got %h want %h", got_q[0], e1); end
  endtask

  task automatic test_stall;
    rec_t e;
    int   tries;
    got_q.delete(); got_cyc.delete();
    make_frame(48'h001122334455, 48'h66778899aabb, 16'h0800, 32'h0A000001, 32'h0A000002,
               8'd17, 16'h1234, 16'h0D80, 8, 1'b0, e);
    for (int b = 0; b < 8; b++) begin
      drive_beat(b, b == 7);
      tries = 0;
      do begin
        m_tready = (b < 5 && tries < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
        tries++;
        @(negedge clk);
        checks++;
        if ({m_tdata, m_tkeep, m_tlast, m_tvalid, s_tready} !== {s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready})
          begin errors++; $display("FAIL stall_mirror: m=%h/%h/%b/%b sr=%b s=%h mr=%b", m_tdata, m_tkeep, m_tlast, m_tvalid, s_tready, s_tdata, m_tready); end
        @(posedge clk); #1;
      end while (!m_tready);
    end
    m_tready = 1'b1;
    idle(5);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL stall_count: got %0d want 1", got_q.size()); end
    else if (got_q[0] !== e) begin errors++; $display("FAIL stall_record: got %h want %h", got_q[0], e); end
  endtask

  task automatic test_reset_mid;
    rec_t e;
    make_frame(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0800, 32'hAC100001, 32'hAC100002,
               8'd17, 16'h5555, 16'h6666, 8, 1'b0, e);
    m_tready = 1'b1;
    for (int b = 0; b < 2; b++) begin drive_beat(b, 1'b0); @(posedge clk); #1; end
    drive_beat(2, 1'b0);
    #2;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    checks++;
    if ({hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_src_ip, hdr_dst_ip, hdr_proto,
         hdr_sport, hdr_dport, hdr_is_udp, hdr_csum_ok, hdr_drop_cnt} !== '0)
      begin errors++; $display("FAIL midreset_zero: valid=%b dst=%h drop=%h, want all zero", hdr_valid, hdr_dst_mac, hdr_drop_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    got_q.delete(); got_cyc.delete();
    make_frame(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0800, 32'hAC100001, 32'hAC100002,
               8'd17, 16'h5555, 16'h6666, 7, 1'b0, e);
    send_frame(7);
    idle(5);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d want 1", got_q.size()); end
    else if (got_q[0] !== e) begin errors++; $display("FAIL midreset_record: got %h want %h", got_q[0], e); end
  endtask

  task automatic test_random;
    rec_t e;
    rec_t exp_q[$];
    int   exp_b4[$];
    int   nb;
    bit   runt;
    got_q.delete(); got_cyc.delete();
    hdr_ready = 1'b1;
    for (int f = 0; f < 24; f++) begin
      runt = ($urandom_range(0, 4) == 0);
      nb   = runt ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 9));
      make_frame({16'($urandom()), $urandom()}, {16'($urandom()), $urandom()},
                 ($urandom_range(0, 3) == 0) ? 16'h86DD : 16'h0800,
                 $urandom(), $urandom(), ($urandom_range(0, 1) == 1) ? 8'd17 : 8'd6,
                 16'($urandom()), 16'($urandom()), nb, ($urandom_range(0, 3) == 0), e);
      send_frame(nb);
      if (runt) exp_drop++;
      else begin exp_q.push_back(e); exp_b4.push_back(b4_cyc); end
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(5);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_record[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        checks++;
        if (got_cyc[i] !== exp_b4[i] + LAT - 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, got_cyc[i], exp_b4[i] + LAT - 1); end
      end
    end
    checks++;
    if (hdr_drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL rand_drop: got %0d want %0d", hdr_drop_cnt, exp_drop); end
  endtask

  initial begin
    rst_n     = 1'b0;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tlast   = 1'b0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b1;
    hdr_ready = 1'b1;
    test_reset();
    test_udp();
    test_corrupt();
    test_runt();
    test_overrun();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ipv4_udp_hdr_parser.md
# ipv4_udp_hdr_parser

Header sequencer that taps the 64-bit receive stream and walks the first five beats of each Ethernet frame. It captures destination and source MAC, ethertype, IPv4 addresses, protocol and UDP ports, and presents them byte-swapped into host order on a registered valid/ready header port. Frame data passes through unmodified. The block sits between the 10G MAC receive interface and the MMIO/packet classification logic, and uses the team's endian conversion functions for every field.

## Interface
- No parameters. Data width is fixed at 64 bits (8 byte lanes). Byte 0 on the wire is in bits [7:0].
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- s_tdata / s_tkeep / s_tlast / s_tvalid  in  64/8/1/1  receive stream
- s_tready  out  1  equals m_tready (combinational)
- m_tdata / m_tkeep / m_tlast / m_tvalid  out  64/8/1/1  pass-through stream, combinational copy of s_*
- m_tready  in  1  downstream ready
- hdr_valid  out  1  header record available
- hdr_ready  in  1  consumer accepts the record
- hdr_dst_mac / hdr_src_mac  out  48 each  host order
- hdr_ethertype  out  16  host order
- hdr_src_ip / hdr_dst_ip  out  32 each  host order
- hdr_proto  out  8  IPv4 protocol
- hdr_sport / hdr_dport  out  16 each  host order
- hdr_is_udp  out  1  ethertype==16'h0800 && proto==8'd17
- hdr_csum_ok  out  1  IPv4 header checksum result
- hdr_drop_cnt  out  16  saturating count of headers lost to runt frames or overrun

## Operation
- A beat is transferred when s_tvalid && m_tready. Only transferred beats advance the parser.
- FSM states: SOF → HDR → BODY.
  - SOF: a beat transfers → beat_cnt=1 → HDR. If s_tlast is set on this beat, the frame is a runt: stay in SOF and increment the drop count.
  - HDR: each transferred beat increments beat_cnt.
    - On beat 4 with s_tlast: header complete, go to SOF.
    - On beat 4 without s_tlast: header complete, go to BODY.
    - s_tlast before beat 4: runt, increment the drop count, go to SOF.
  - BODY: stay until a beat with s_tlast transfers, then go to SOF.
- Field capture uses byte offsets with a fixed 20-byte IPv4 header. No VLAN and no options are handled.
  - Beat 0: dst MAC from bytes 0-5; src MAC high bytes from 6-7.
  - Beat 1: src MAC low bytes from 8-11; ethertype from 12-13.
  - Beat 2: proto from byte 23.
  - Beat 3: src IP from bytes 26-29; dst IP high half from bytes 30-31.
  - Beat 4: dst IP low half from bytes 32-33; sport from 34-35; dport from 36-37.
- Every multi-byte field is converted with endian_conv16, endian_conv32 or endian_conv48 on its assembled network-order bytes.
- The output record is registered.
  - It loads only on header complete while hdr_valid==0, or in the same cycle that hdr_valid && hdr_ready.
  - It stays stable while hdr_valid=1 and hdr_ready=0.
- Overrun: if a header completes while hdr_valid=1 and hdr_ready=0, the new header is discarded, the old record is kept and the drop count increments.
- hdr_drop_cnt saturates at 16'hFFFF.
- Reset values: FSM=SOF, beat_cnt=0, hdr_valid=0, all hdr_* fields=0, hdr_csum_ok=0, hdr_drop_cnt=0. An asynchronous reset mid-frame discards the frame. After reset the parser treats the next transferred beat as SOF.

## Timing
- hdr_valid rises on the first clk edge after the beat-4 transfer, giving 1 cycle of latency. This is 2 cycles with the checksum check enabled; see Configuration.
- If hdr_ready is held high, hdr_valid stays high for exactly 1 cycle per header.
- The pass-through stream adds zero latency. The parser never back-pressures the stream.
- Back-to-back minimum frames (5 beats each) are supported at full rate if hdr_ready stays high.

## Configuration
- IPV4_CSUM_CHK_EN defined:
  - A 20-bit accumulator sums the ten 16-bit header words (bytes 14-33) as they transfer in beats 1-4.
  - A fold stage after beat 4 performs end-around carry twice.
  - hdr_csum_ok = (folded sum == 16'hFFFF) && ethertype==16'h0800.
  - Header latency is 2 cycles. The overrun and back-to-back rules apply at the later load point.
- IPV4_CSUM_CHK_EN undefined: hdr_csum_ok is forced to 1 on every loaded record, and latency is 1 cycle.

## Test plan
- UDP frame, 8 beats: dst 00:11:22:33:44:55, src 66:77:88:99:aa:bb, 10.0.0.1 → 10.0.0.2, sport 0x1234, dport 0x0d80, with hdr_ready=1.
  - hdr_valid pulses for 1 cycle, 1 clk after beat 4 (2 with the macro).
  - hdr_dst_mac=48'h001122334455, hdr_src_ip=32'h0A000001, hdr_dport=16'h0D80, hdr_is_udp=1, hdr_csum_ok=1.
- Same frame with one header byte corrupted, macro defined → hdr_csum_ok=0, with all other fields still correct.
- 3-beat runt frame, then a valid frame → no hdr_valid for the runt, hdr_drop_cnt=1, and the second frame is parsed correctly.
- Two 5-beat frames back to back with hdr_ready=0 → the first record is held, the second is dropped, and hdr_drop_cnt=1. Raising hdr_ready clears hdr_valid on the next cycle.
- m_tready toggled 50% during the header beats → captured fields are identical to the no-stall run, and m_* mirrors s_* every cycle.
- rst_n asserted during beat 2, then released → all outputs are 0. The following frame is parsed from SOF with correct fields.
